serial_parity_frame_chk: RTL and testbench
==========================================

Name: serial_parity_frame_chk

Overview:
- Parametrised successor to the single-bit serial parity detector.
- Accepts a serial bit stream qualified by x_valid and groups it into frames of WORD_W data bits followed by one parity bit.
- Checks each frame against even or odd parity, deserialises the data word, and flags errors per frame.
- Sits between a serial line receiver and downstream word consumers.

Parameters:
- WORD_W, 8, data bits per frame (legal range 1..32).
- ERR_CNT_W, 8, width of the error counter (used only when the optional feature is compiled in).

Ports:
- clk  input  1  system clock; all logic rising-edge.
- rst_n  input  1  synchronous active-low reset.
- x  input  1  serial data/parity bit.
- x_valid  input  1  x is sampled on a rising clk edge only when x_valid=1.
- odd_mode  input  1  0 = even parity, 1 = odd parity; latched at the first bit of each frame.
- z  output  1  running XOR of the data bits accepted so far in the current frame.
- data_out  output  WORD_W  deserialised data word, LSB received first.
- frame_done  output  1  one-cycle pulse; data_out and parity_err are valid while it is high.
- parity_err  output  1  1 = the received parity bit mismatched the expected value.
- err_cnt  output  ERR_CNT_W  count of frames with errors (only when the optional feature is compiled in).

Behaviour:
- Synchronous reset, active-low (rst_n=0 sampled on a rising clk edge):
  - state=IDLE, bit counter=0, z=0, data_out=0, frame_done=0, parity_err=0, latched mode=0.
  - Reset takes priority over everything, including mid-frame.
  - A partial frame is discarded silently: no frame_done.
- x_valid=0: all state, the counter, z and the shift register hold.
  - frame_done is forced to 0 on any cycle after its single pulse.
- States:
  - IDLE:
    - On a valid bit: capture it as data bit 0, latch odd_mode, counter=1.
    - Next state is DATA, or PAR if WORD_W=1.
  - DATA:
    - Each valid bit goes into data position [counter]; counter increments.
    - When counter reaches WORD_W, next state is PAR.
  - PAR:
    - The valid bit is the parity bit.
    - expected = z_final XOR latched mode, where z_final is the XOR of all WORD_W data bits.
    - parity_err = (x != expected).
    - The assembled word moves to data_out; frame_done=1 for exactly one cycle.
    - z clears to 0, counter clears to 0, next state is IDLE.
- z update:
  - Registered; it reflects each accepted data bit one cycle after that bit's sampling edge.
  - Parity bits never enter z.
- Latency: frame_done, data_out and parity_err are registered outputs, visible the cycle after the parity-bit edge.
- Back-to-back frames:
  - A valid bit on the cycle frame_done is high is accepted as bit 0 of the next frame (zero-bubble).
  - data_out holds until the next frame_done.
- parity_err and data_out hold their last values between pulses; only frame_done pulses.
- odd_mode changes mid-frame have no effect on the current frame.

Optional Feature:
- Macro: SERIAL_PARITY_ERR_CNT_EN.
- Defined:
  - err_cnt port is present.
  - Increments by 1 on every frame_done with parity_err=1.
  - Saturates at all-ones (no wrap).
  - Cleared to 0 only by rst_n.
- Undefined: the err_cnt port and its logic are absent; all other behaviour is identical.

Test Plan (WORD_W=8, x_valid=1 unless stated, bits LSB first):
- Even mode, data 8'hA5 (bits 1,0,1,0,0,1,0,1), parity bit 0 -> frame_done pulses once 1 cycle after the parity edge; data_out=8'hA5, parity_err=0; z steps 1,1,0,0,0,1,1,0 then clears to 0.
- Even mode, 8'hA5 with parity bit 1 -> parity_err=1, data_out=8'hA5; err_cnt=1 if the macro is defined.
- odd_mode=1 at bit 0, data 8'h07, parity bit 0 -> parity_err=0. Toggling odd_mode to 0 during bits 3..7 gives the same result, proving the mode latch.
- Gaps: same 8'hA5 frame with x_valid=0 for 3 random cycles between bits 2/3 and 7/parity -> identical outputs; z and the counter hold during the gaps.
- Reset mid-frame: rst_n=0 for 1 cycle after 5 bits, then a full 8'h3C frame with even parity 0 -> exactly one frame_done, data_out=8'h3C, parity_err=0; err_cnt=0.
- Back-to-back: 3 frames with no idle cycles (8'hFF/p0, 8'h01/p0 wrong, 8'h80/p1) -> three pulses exactly 9 cycles apart.
  - parity_err sequence is 0,1,0.
  - err_cnt=1 (macro defined).
  - With ERR_CNT_W=2 and 5 erroneous frames, err_cnt saturates at 3.

Source files
------------

// File: rtl/serial_parity_frame_chk.sv
// serial_parity_frame_chk
// Groups a qualified serial bit stream into frames of WORD_W data bits
// (LSB first) followed by one parity bit. Each frame is deserialised and
// checked against even or odd parity. The parity sense is latched at the
// first bit of the frame.
// Optional feature macro: SERIAL_PARITY_ERR_CNT_EN adds a saturating
// err_cnt output that counts frames with a parity error.

module serial_parity_frame_chk #(
    parameter int WORD_W    = 8,
    parameter int ERR_CNT_W = 8
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              x,
    input  logic              x_valid,
    input  logic              odd_mode,
    output logic              z,
    output logic [WORD_W-1:0] data_out,
    output logic              frame_done,
    output logic              parity_err
`ifdef SERIAL_PARITY_ERR_CNT_EN
    ,
    output logic [ERR_CNT_W-1:0] err_cnt
`endif
);

    // The counter must be able to hold the value WORD_W itself.
    localparam int CNT_W = (WORD_W < 2) ? 1 : $clog2(WORD_W + 1);
    localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(WORD_W);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        DATA = 2'd1,
        PAR  = 2'd2
    } state_t;

    state_t            state;
    logic [CNT_W-1:0]  cnt;
    logic [WORD_W-1:0] shreg;
    logic              mode;
    logic              par_bad;

    // A parity bit is bad when it differs from the data XOR combined with the latched sense.
    assign par_bad = x ^ (z ^ mode);

    // Frame FSM: captures data bits, tracks running parity and publishes finished frames.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state      <= IDLE;
            cnt        <= '0;
            shreg      <= '0;
            mode       <= 1'b0;
            z          <= 1'b0;
            data_out   <= '0;
            frame_done <= 1'b0;
            parity_err <= 1'b0;
        end else begin
            frame_done <= 1'b0;
            if (x_valid) begin
                case (state)
                    IDLE: begin
                        shreg <= WORD_W'(x);
                        mode  <= odd_mode;
                        z     <= x;
                        cnt   <= CNT_ONE;
                        state <= (WORD_W == 1) ? PAR : DATA;
                    end
                    DATA: begin
                        shreg <= shreg | (WORD_W'(x) << cnt);
                        z     <= z ^ x;
                        cnt   <= cnt + CNT_ONE;
                        if ((cnt + CNT_ONE) == CNT_LAST) begin
                            state <= PAR;
                        end
                    end
                    PAR: begin
                        parity_err <= par_bad;
                        data_out   <= shreg;
                        frame_done <= 1'b1;
                        z          <= 1'b0;
                        cnt        <= '0;
                        state      <= IDLE;
                    end
                    default: begin
                        state <= IDLE;
                        cnt   <= '0;
                        z     <= 1'b0;
                    end
                endcase
            end
        end
    end

`ifdef SERIAL_PARITY_ERR_CNT_EN
    // Saturating count of frames whose parity bit was wrong; only reset clears it.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            err_cnt <= '0;
        end else if (x_valid && (state == PAR) && par_bad && (err_cnt != '1)) begin
            err_cnt <= err_cnt + ERR_CNT_W'(1);
        end
    end
`endif

endmodule

// File: tb/tb_serial_parity_frame_chk.sv
// tb_serial_parity_frame_chk
// Directed bench for serial_parity_frame_chk (WORD_W=8). A frame-level model
// predicts every output each cycle, and literal expectations pin key frames.
// Define SERIAL_PARITY_ERR_CNT_EN to also exercise err_cnt and its saturation.

module tb_serial_parity_frame_chk;

    logic       clk;
    logic       rst_n;
    logic       x;
    logic       x_valid;
    logic       odd_mode;
    logic       z;
    logic [7:0] data_out;
    logic       frame_done;
    logic       parity_err;
`ifdef SERIAL_PARITY_ERR_CNT_EN
    logic [7:0] err_cnt;
    logic       sat_z;
    logic [7:0] sat_data_out;
    logic       sat_frame_done;
    logic       sat_parity_err;
    logic [1:0] sat_err_cnt;
`endif

    int checks   = 0;
    int failures = 0;
    int cyc      = 0;

    serial_parity_frame_chk #(.WORD_W(8), .ERR_CNT_W(8)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .x          (x),
        .x_valid    (x_valid),
        .odd_mode   (odd_mode),
        .z          (z),
        .data_out   (data_out),
        .frame_done (frame_done),
        .parity_err (parity_err)
`ifdef SERIAL_PARITY_ERR_CNT_EN
        ,
        .err_cnt    (err_cnt)
`endif
    );

`ifdef SERIAL_PARITY_ERR_CNT_EN
    serial_parity_frame_chk #(.WORD_W(8), .ERR_CNT_W(2)) sat_dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .x          (x),
        .x_valid    (x_valid),
        .odd_mode   (odd_mode),
        .z          (sat_z),
        .data_out   (sat_data_out),
        .frame_done (sat_frame_done),
        .parity_err (sat_parity_err),
        .err_cnt    (sat_err_cnt)
    );
`endif

    // 10 ns clock
    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Frame-level model state
    int         m_nbits = 0;
    logic [7:0] m_word  = '0;
    bit         m_mode  = 1'b0;
    bit         e_z     = 1'b0;
    logic [7:0] e_data  = '0;
    bit         e_done  = 1'b0;
    bit         e_err   = 1'b0;
    int         e_errs  = 0;

    // Observed pulses
    int pulse_cyc[$];
    bit pulse_err[$];

    task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("[TB] FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // Model update at each edge, then compare DUT outputs 1 ns later
    always begin
        @(posedge clk);
        cyc++;
        e_done = 1'b0;
        if (!rst_n) begin
            m_nbits = 0;
            m_word  = '0;
            e_z     = 1'b0;
            e_data  = '0;
            e_err   = 1'b0;
            e_errs  = 0;
        end else if (x_valid) begin
            if (m_nbits == 0) m_mode = odd_mode;
            if (m_nbits < 8) begin
                m_word[m_nbits] = x;
                m_nbits++;
                e_z = ^m_word;
            end else begin
                e_err  = (x != ((^m_word) ^ m_mode));
                e_data = m_word;
                e_done = 1'b1;
                if (e_err) e_errs++;
                m_nbits = 0;
                m_word  = '0;
                e_z     = 1'b0;
            end
        end
        #1;
        checkOutput("z", 32'(z), 32'(e_z));
        checkOutput("frame_done", 32'(frame_done), 32'(e_done));
        checkOutput("data_out", 32'(data_out), 32'(e_data));
        checkOutput("parity_err", 32'(parity_err), 32'(e_err));
`ifdef SERIAL_PARITY_ERR_CNT_EN
        checkOutput("err_cnt", 32'(err_cnt), 32'((e_errs > 255) ? 255 : e_errs));
        checkOutput("sat_err_cnt", 32'(sat_err_cnt), 32'((e_errs > 3) ? 3 : e_errs));
`endif
        if (frame_done === 1'b1) begin
            pulse_cyc.push_back(cyc);
            pulse_err.push_back(parity_err);
        end
    end

    // Drive one cycle of inputs at the falling edge, return after the next rising edge settles
    task automatic applyStimulus(input bit xv, input bit v, input bit om);
        @(negedge clk);
        x        = xv;
        x_valid  = v;
        odd_mode = om;
        @(posedge clk);
        #2;
    endtask

    task automatic doReset();
        @(negedge clk);
        rst_n   = 1'b0;
        x_valid = 1'b0;
        @(posedge clk);
        #2;
        rst_n = 1'b1;
    endtask

    // Sends 8 data bits LSB first and the parity bit; odd_mode switches from om_a to om_b at bit 3
    task automatic sendFrame(input logic [7:0] d, input bit p, input bit om_a, input bit om_b);
        for (int i = 0; i < 8; i++) applyStimulus(d[i], 1'b1, (i < 3) ? om_a : om_b);
        applyStimulus(p, 1'b1, om_b);
    endtask

    logic [7:0] a5_bits;
    logic [7:0] z_steps;
    int         n_before;

    initial begin
        rst_n    = 1'b0;
        x        = 1'b0;
        x_valid  = 1'b0;
        odd_mode = 1'b0;
        a5_bits  = 8'hA5;
        z_steps  = 8'b0110_0011;   // z after bits 0..7 = 1,1,0,0,0,1,1,0 (bit i of this vector)
        repeat (2) @(posedge clk);
        #2;
        rst_n = 1'b1;

        // Reset state
        checkOutput("rst_z", 32'(z), 32'h0);
        checkOutput("rst_data_out", 32'(data_out), 32'h0);
        checkOutput("rst_frame_done", 32'(frame_done), 32'h0);
        checkOutput("rst_parity_err", 32'(parity_err), 32'h0);

        // Even mode A5, correct parity, with z stepping
        for (int i = 0; i < 8; i++) begin
            applyStimulus(a5_bits[i], 1'b1, 1'b0);
            checkOutput($sformatf("a5_z_step%0d", i), 32'(z), 32'(z_steps[i]));
        end
        applyStimulus(1'b0, 1'b1, 1'b0);
        checkOutput("a5_done", 32'(frame_done), 32'h1);
        checkOutput("a5_data", 32'(data_out), 32'hA5);
        checkOutput("a5_err", 32'(parity_err), 32'h0);
        checkOutput("a5_z_clear", 32'(z), 32'h0);
        applyStimulus(1'b0, 1'b0, 1'b0);
        checkOutput("a5_done_drop", 32'(frame_done), 32'h0);
        checkOutput("a5_data_hold", 32'(data_out), 32'hA5);

        // Even mode A5, wrong parity
        sendFrame(8'hA5, 1'b1, 1'b0, 1'b0);
        checkOutput("a5bad_err", 32'(parity_err), 32'h1);
        checkOutput("a5bad_data", 32'(data_out), 32'hA5);
`ifdef SERIAL_PARITY_ERR_CNT_EN
        checkOutput("a5bad_err_cnt", 32'(err_cnt), 32'h1);
`endif
        applyStimulus(1'b0, 1'b0, 1'b0);

        // Odd mode 07, parity 0, then with odd_mode dropped from bit 3 onward
        sendFrame(8'h07, 1'b0, 1'b1, 1'b1);
        checkOutput("odd07_err", 32'(parity_err), 32'h0);
        checkOutput("odd07_data", 32'(data_out), 32'h07);
        sendFrame(8'h07, 1'b0, 1'b1, 1'b0);
        checkOutput("odd07_latch_err", 32'(parity_err), 32'h0);
        checkOutput("odd07_latch_done", 32'(frame_done), 32'h1);
        applyStimulus(1'b0, 1'b0, 1'b0);

        // A5 with gaps of 3 random-x idle cycles after bit 2 and after bit 7
        for (int i = 0; i < 8; i++) begin
            applyStimulus(a5_bits[i], 1'b1, 1'b0);
            if (i == 2 || i == 7) begin
                for (int g = 0; g < 3; g++) applyStimulus(1'($urandom_range(0, 1)), 1'b0, 1'($urandom_range(0, 1)));
                checkOutput($sformatf("gap_z_hold%0d", i), 32'(z), 32'(z_steps[i]));
                checkOutput($sformatf("gap_no_done%0d", i), 32'(frame_done), 32'h0);
            end
        end
        applyStimulus(1'b0, 1'b1, 1'b0);
        checkOutput("gap_done", 32'(frame_done), 32'h1);
        checkOutput("gap_data", 32'(data_out), 32'hA5);
        checkOutput("gap_err", 32'(parity_err), 32'h0);
        applyStimulus(1'b0, 1'b0, 1'b0);

        // Reset after 5 bits, then a full 3C frame
        for (int i = 0; i < 5; i++) applyStimulus(1'b1, 1'b1, 1'b0);
        doReset();
        n_before = pulse_cyc.size();
        sendFrame(8'h3C, 1'b0, 1'b0, 1'b0);
        applyStimulus(1'b0, 1'b0, 1'b0);
        checkOutput("rstmid_pulses", 32'(pulse_cyc.size() - n_before), 32'h1);
        checkOutput("rstmid_data", 32'(data_out), 32'h3C);
        checkOutput("rstmid_err", 32'(parity_err), 32'h0);
`ifdef SERIAL_PARITY_ERR_CNT_EN
        checkOutput("rstmid_err_cnt", 32'(err_cnt), 32'h0);
`endif

        // Three back-to-back frames, no idle cycles
        n_before = pulse_cyc.size();
        sendFrame(8'hFF, 1'b0, 1'b0, 1'b0);
        sendFrame(8'h01, 1'b0, 1'b0, 1'b0);
        sendFrame(8'h80, 1'b1, 1'b0, 1'b0);
        applyStimulus(1'b0, 1'b0, 1'b0);
        checkOutput("b2b_pulses", 32'(pulse_cyc.size() - n_before), 32'h3);
        if (pulse_cyc.size() - n_before == 3) begin
            checkOutput("b2b_gap1", 32'(pulse_cyc[n_before + 1] - pulse_cyc[n_before]), 32'd9);
            checkOutput("b2b_gap2", 32'(pulse_cyc[n_before + 2] - pulse_cyc[n_before + 1]), 32'd9);
            checkOutput("b2b_err0", 32'(pulse_err[n_before]), 32'h0);
            checkOutput("b2b_err1", 32'(pulse_err[n_before + 1]), 32'h1);
            checkOutput("b2b_err2", 32'(pulse_err[n_before + 2]), 32'h0);
        end
        checkOutput("b2b_data", 32'(data_out), 32'h80);
`ifdef SERIAL_PARITY_ERR_CNT_EN
        checkOutput("b2b_err_cnt", 32'(err_cnt), 32'h1);

        // Five erroneous frames: the 2-bit counter must stick at 3
        doReset();
        for (int f = 0; f < 5; f++) sendFrame(8'h01, 1'b0, 1'b0, 1'b0);
        applyStimulus(1'b0, 1'b0, 1'b0);
        checkOutput("sat_err_cnt_lit", 32'(sat_err_cnt), 32'h3);
        checkOutput("sat_main_err_cnt_lit", 32'(err_cnt), 32'h5);
`endif

        repeat (3) applyStimulus(1'b0, 1'b0, 1'b0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
